// File: rtl/vga_sync_rx.sv
// vga_sync_rx: checks incoming VGA sync timing, locks after LOCK_FRAMES good frames and
// recovers active-area pixel coordinates/data. Define VGA_RX_MEAS_EN for period measurement outputs.
module vga_sync_rx #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_START     = 144,
  parameter int V_START     = 35,
  parameter int H_VALID     = 640,
  parameter int V_VALID     = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb_data,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic        err_pulse,
  output logic [10:0] h_total_meas,
  output logic [10:0] v_total_meas
);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_CHECK,
    ST_LOCKED
  } state_e;

  localparam int GW = $clog2(LOCK_FRAMES + 1);

  logic        hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
  logic [15:0] rgb_q;
  logic        hs_rise, vs_rise;
  logic [10:0] hcnt_q, hcnt_d, h_pos;
  logic [10:0] line_q, line_d;
  logic        line_bad, h_timeout, vs_bad, any_bad;

  state_e          state_q;
  logic [GW-1:0]   good_q, good_inc;
  logic            frame_bad_q;
  logic            locked_q, err_q;

  logic        pix_valid_d, frame_start_d;
  logic [9:0]  pix_x_d, pix_y_d;
  logic        pix_valid_q, frame_start_q;
  logic [9:0]  pix_x_q, pix_y_q;
  logic [15:0] pix_data_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1_q <= 1'b0;
      hs_s2_q <= 1'b0;
      vs_s1_q <= 1'b0;
      vs_s2_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hs_s1_q <= hsync;
      hs_s2_q <= hs_s1_q;
      vs_s1_q <= vsync;
      vs_s2_q <= vs_s1_q;
      rgb_q   <= rgb_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hs_rise = hs_s1_q & ~hs_s2_q;
    vs_rise = vs_s1_q & ~vs_s2_q;
    h_pos   = hs_rise ? 11'd0 : hcnt_q;
    hcnt_d  = (h_pos == 11'h7FF) ? h_pos : h_pos + 11'd1;
    line_d  = line_q;
    if (hs_rise) begin
      if (vs_rise)                 line_d = 11'd0;
      else if (line_q != 11'h7FF)  line_d = line_q + 11'd1;
    end
    // hcnt_q equals the distance from the previous hs_rise, i.e. the line period.
    line_bad  = hs_rise & (hcnt_q != 11'(H_TOTAL));
    h_timeout = ~hs_rise & (hcnt_q == 11'(H_TOTAL));
    vs_bad    = vs_rise & (~hs_rise | (line_q != 11'(V_TOTAL - 1)));
    any_bad   = line_bad | h_timeout | vs_bad;
    good_inc  = good_q + GW'(1);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      line_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      line_q <= line_d;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_UNLOCKED;
      good_q      <= '0;
      frame_bad_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_UNLOCKED: begin
          if (vs_rise) begin
            state_q     <= ST_CHECK;
            good_q      <= '0;
            frame_bad_q <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (vs_rise) begin
            frame_bad_q <= 1'b0;
            if (frame_bad_q | any_bad) begin
              good_q <= '0;
            end else if (good_inc == GW'(LOCK_FRAMES)) begin
              good_q   <= '0;
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
            end else begin
              good_q <= good_inc;
            end
          end else begin
            frame_bad_q <= frame_bad_q | any_bad;
          end
        end
        ST_LOCKED: begin
          if (any_bad) begin
            state_q  <= ST_UNLOCKED;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_UNLOCKED;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pix_valid_d = (state_q == ST_LOCKED)
                & (h_pos >= 11'(H_START)) & (h_pos < 11'(H_START + H_VALID))
                & (line_d >= 11'(V_START)) & (line_d < 11'(V_START + V_VALID));
    pix_x_d       = pix_valid_d ? 10'(h_pos - 11'(H_START)) : 10'h3FF;
    pix_y_d       = pix_valid_d ? 10'(line_d - 11'(V_START)) : 10'h3FF;
    frame_start_d = pix_valid_d & (pix_x_d == 10'd0) & (pix_y_d == 10'd0);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q   <= 1'b0;
      pix_x_q       <= 10'h3FF;
      pix_y_q       <= 10'h3FF;
      pix_data_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_valid_d ? rgb_q : 16'd0;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_data    = pix_data_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign err_pulse   = err_q;

`ifdef VGA_RX_MEAS_EN
  logic [10:0] h_meas_q, v_meas_q;

  // Measurements run in every lock state so a mis-timed source can be diagnosed.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_meas_q <= '0;
      v_meas_q <= '0;
    end else begin
      if (hs_rise) h_meas_q <= hcnt_q;
      if (vs_rise) v_meas_q <= line_q + 11'd1;
    end
  end

  assign h_total_meas = h_meas_q;
  assign v_total_meas = v_meas_q;
`else
  assign h_total_meas = 11'd0;
  assign v_total_meas = 11'd0;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: frame-level vector table driving a small-geometry VGA source into vga_sync_rx,
// with a per-cycle pixel scoreboard and hand sequences for mid-operation reset.
module tb_vga_sync_rx;

  localparam int H_T  = 20;
  localparam int V_T  = 12;
  localparam int H_S  = 5;
  localparam int V_S  = 3;
  localparam int H_V  = 10;
  localparam int V_V  = 6;
  localparam int HS_W = 2;
  localparam int VS_W = 2;

  logic        vga_clk = 1'b0;
  logic        rst_n;
  logic        hsync, vsync;
  logic [15:0] rgb_data;
  logic        pix_valid, frame_start, locked, err_pulse;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] pix_data;
  logic [10:0] h_total_meas, v_total_meas;

  vga_sync_rx #(
    .H_TOTAL(H_T), .V_TOTAL(V_T), .H_START(H_S), .V_START(V_S),
    .H_VALID(H_V), .V_VALID(V_V), .LOCK_FRAMES(2)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .rgb_data(rgb_data),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .locked(locked), .err_pulse(err_pulse),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int  lines;
    int  stretch;
    bit  vs_on;
    int  pix_last;
    bit  exp_lock;
    int  exp_err;
  } frame_vec_t;

  typedef struct {
    int          due;
    bit          chk;
    bit          valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] data;
    bit          fs;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_fail = 0;
  int   cyc = 0;
  int   err_cnt = 0, pix_cnt = 0, fs_cnt = 0;
  int   first_rise = -1, err_cyc = -1;
  bit   locked_prev = 1'b0;
  int   frame_no = 0, frame_cyc = -1, stretch_cyc = -1;

  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: event counters plus scoreboard pop at the due cycle.
  always @(negedge vga_clk) begin
    exp_t e;
    if (locked && !locked_prev && first_rise < 0) first_rise = cyc;
    locked_prev = locked;
    if (err_pulse === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (pix_valid === 1'b1) pix_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due == cyc && e.chk) begin
        check("pix_valid", 32'(pix_valid), 32'(e.valid));
        check("pix_x", 32'(pix_x), 32'(e.x));
        check("pix_y", 32'(pix_y), 32'(e.y));
        check("pix_data", 32'(pix_data), 32'(e.data));
        check("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
  end

  task automatic gen_frame(input int lines, input int stretch, input bit vs_on,
                           input int pix_last, input bit chk);
    exp_t e;
    int   len;
    bit   v;
    frame_no++;
    for (int l = 0; l < lines; l++) begin
      len = (l == stretch) ? H_T + 1 : H_T;
      for (int h = 0; h < len; h++) begin
        @(negedge vga_clk);
        hsync    = (h < HS_W);
        vsync    = vs_on && (l < VS_W);
        rgb_data = 16'((frame_no * 4099) ^ (l * 64) ^ h);
        if (l == 0 && h == 0) frame_cyc = cyc;
        if (l == stretch && h == H_T) stretch_cyc = cyc;
        v = chk && (l <= pix_last) && (h >= H_S) && (h < H_S + H_V) && (l >= V_S) && (l < V_S + V_V);
        e.due   = cyc + 2;
        e.chk   = chk;
        e.valid = v;
        e.x     = v ? 10'(h - H_S) : 10'h3FF;
        e.y     = v ? 10'(l - V_S) : 10'h3FF;
        e.data  = v ? rgb_data : 16'd0;
        e.fs    = v && (h == H_S) && (l == V_S);
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_x"}, 32'(pix_x), 32'h3FF);
    check({tag, "_pix_y"}, 32'(pix_y), 32'h3FF);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
    check({tag, "_h_meas"}, 32'(h_total_meas), 32'd0);
    check({tag, "_v_meas"}, 32'(v_total_meas), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_vec_t tbl[21];
    int e0, p0, f0, exp_pix;

    // lines, stretch line, vsync on, last emitted line, locked at end, err pulses
    tbl[0]  = '{12, -1, 1'b1, -1, 1'b0, 0};
    tbl[1]  = '{12, -1, 1'b1, -1, 1'b0, 0};
    tbl[2]  = '{12, -1, 1'b1, 11, 1'b1, 0};
    tbl[3]  = '{12, -1, 1'b1, 11, 1'b1, 0};
    tbl[4]  = '{12,  5, 1'b1,  5, 1'b0, 1};
    tbl[5]  = '{12, -1, 1'b1, -1, 1'b0, 0};
    tbl[6]  = '{12, -1, 1'b1, -1, 1'b0, 0};
    tbl[7]  = '{12, -1, 1'b1, 11, 1'b1, 0};
    tbl[8]  = '{12, -1, 1'b0, -1, 1'b1, 0};
    tbl[9]  = '{12, -1, 1'b1, -1, 1'b0, 1};
    tbl[10] = '{12, -1, 1'b1, -1, 1'b0, 0};
    tbl[11] = '{12, -1, 1'b1, -1, 1'b0, 0};
    tbl[12] = '{12, -1, 1'b1, 11, 1'b1, 0};
    tbl[13] = '{11, -1, 1'b1, 10, 1'b1, 0};
    tbl[14] = '{11, -1, 1'b1, -1, 1'b0, 1};
    tbl[15] = '{11, -1, 1'b1, -1, 1'b0, 0};
    tbl[16] = '{11, -1, 1'b1, -1, 1'b0, 0};
    tbl[17] = '{11, -1, 1'b1, -1, 1'b0, 0};
    tbl[18] = '{12, -1, 1'b1, -1, 1'b0, 0};
    tbl[19] = '{12, -1, 1'b1, -1, 1'b0, 0};
    tbl[20] = '{12, -1, 1'b1, 11, 1'b1, 0};

    rst_n = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    rgb_data = '0;
    repeat (3) @(negedge vga_clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      e0 = err_cnt;
      p0 = pix_cnt;
      f0 = fs_cnt;
      gen_frame(tbl[i].lines, tbl[i].stretch, tbl[i].vs_on, tbl[i].pix_last, 1'b1);
      exp_pix = 0;
      for (int l = V_S; l < V_S + V_V; l++)
        if (l <= tbl[i].pix_last && l < tbl[i].lines) exp_pix += H_V;
      check($sformatf("f%0d_locked", i), 32'(locked), 32'(tbl[i].exp_lock));
      check($sformatf("f%0d_err_cnt", i), 32'(err_cnt - e0), 32'(tbl[i].exp_err));
      check($sformatf("f%0d_pix_cnt", i), 32'(pix_cnt - p0), 32'(exp_pix));
      check($sformatf("f%0d_fs_cnt", i), 32'(fs_cnt - f0), (tbl[i].pix_last >= V_S) ? 32'd1 : 32'd0);
      if (i == 2) check("lock_rise_cyc", 32'(first_rise), 32'(frame_cyc + 2));
      if (i == 4) check("timeout_err_cyc", 32'(err_cyc), 32'(stretch_cyc + 2));
      if (i == 17) begin
`ifdef VGA_RX_MEAS_EN
        check("h_total_meas", 32'(h_total_meas), 32'(H_T));
        check("v_total_meas", 32'(v_total_meas), 32'(V_T - 1));
`else
        check("h_total_meas", 32'(h_total_meas), 32'd0);
        check("v_total_meas", 32'(v_total_meas), 32'd0);
`endif
      end
    end

    // Reset mid-frame while locked, released while hsync is high (spurious rise).
    e0 = err_cnt;
    fork
      begin
        for (int k = 0; k < 4; k++) gen_frame(V_T, -1, 1'b1, -1, 1'b0);
      end
      begin
        repeat (107) @(negedge vga_clk);
        check("pre_reset_locked", 32'(locked), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        repeat (15) @(negedge vga_clk);
        rst_n = 1'b1;
      end
    join
    check("relock_within_3", 32'(locked), 32'd1);
    check("relock_err_cnt", 32'(err_cnt - e0), 32'd0);

    p0 = pix_cnt;
    f0 = fs_cnt;
    gen_frame(V_T, -1, 1'b1, 11, 1'b1);
    check("post_rst_pix_cnt", 32'(pix_cnt - p0), 32'(H_V * V_V));
    check("post_rst_fs_cnt", 32'(fs_cnt - f0), 32'd1);
    check("post_rst_locked", 32'(locked), 32'd1);

    repeat (4) @(negedge vga_clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Receive-side counterpart of the VGA timing generator. Samples hsync, vsync and 16-bit pixel data, and verifies the 800x525 frame timing. Once lock is established, it recovers active-area pixel coordinates and data. It sits behind the generator (loopback capture, self-check) or on any same-clock VGA-format source, and feeds frame-buffer writers and checkers.

## Interface
Parameters:
- H_TOTAL, 800: expected clocks per line
- V_TOTAL, 525: expected lines per frame
- H_START, 144: h position of first active pixel (sync+back+left)
- V_START, 35: line index of first active line
- H_VALID, 640: active pixels per line
- V_VALID, 480: active lines per frame
- LOCK_FRAMES, 2: consecutive good frames required to lock

Ports:
- vga_clk  in  1  pixel clock; source is synchronous to it
- rst_n  in  1  reset, asynchronous, active-low
- hsync  in  1  line sync, active-high
- vsync  in  1  frame sync, active-high
- rgb_data  in  16  pixel data
- pix_valid  out  1  registered pixel strobe
- pix_x  out  10  active x, 0..639; 10'h3FF when pix_valid=0
- pix_y  out  10  active y, 0..479; 10'h3FF when pix_valid=0
- pix_data  out  16  pixel data; 0 when pix_valid=0
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- locked  out  1  timing lock status
- err_pulse  out  1  one-cycle pulse on loss of lock
- h_total_meas  out  11  last measured line period (see Configuration)
- v_total_meas  out  11  last measured frame length in lines (see Configuration)

## Operation
- Input stage: hsync, vsync and rgb_data are registered once (hs_d, vs_d, rgb_d), plus a second delay (hs_d2, vs_d2) for edge detection. All reset to 0.
- hs_rise = hs_d & ~hs_d2. vs_rise = vs_d & ~vs_d2.
- h position of the sample in rgb_d is 0 on hs_rise; otherwise it is hcnt.
- hcnt: set to 1 on hs_rise, else incremented. It is 11-bit and saturates at 2047.
- Line index: cleared to 0 on hs_rise when vs_rise is also present; incremented on any other hs_rise. It is 11-bit and saturates.
- Line period check: at hs_rise, the period equals the current h position + 1 and must equal H_TOTAL. A line that reaches h position H_TOTAL without an hs_rise is also bad.
- Frame check: at vs_rise, the line index must equal V_TOTAL-1. A vs_rise without a coincident hs_rise is bad.
- Lock FSM:
  - UNLOCKED (reset state): on first vs_rise -> CHECK, good count = 0.
  - CHECK: track whether any bad line or bad vsync occurs within the current frame. At each vs_rise:
    - frame good: good count + 1; reaching LOCK_FRAMES -> LOCKED.
    - frame bad: good count = 0, stay in CHECK.
  - LOCKED: any bad line period, timeout or bad vs_rise -> UNLOCKED, with err_pulse = 1 for one cycle.
- locked = 1 only in LOCKED.
- Output: pix_valid = locked & h in [H_START, H_START+H_VALID) & line in [V_START, V_START+V_VALID).
  - pix_x = h - H_START, pix_y = line - V_START (10-bit truncation).
  - pix_data = rgb_d.
  - All outputs are registered.
- frame_start = pix_valid & x==0 & y==0.

## Timing
- Reset values: pix_valid 0, pix_x/pix_y 10'h3FF, pix_data 0, frame_start 0, locked 0, err_pulse 0, meas outputs 0, FSM UNLOCKED.
- Latency: a pixel driven on rgb_data in cycle t appears on pix_* in cycle t+2. Sync edges have the same 2-cycle alignment.
- locked rises in the cycle after the vs_rise that completes the LOCK_FRAMES-th good frame.
- The first pix_valid after lock is the next frame's (0,0); partial frames are never emitted.
- Loss of lock: on the failing edge or timeout, locked falls, err_pulse fires and pix_valid is 0 from the next cycle.
- Reset mid-operation: everything returns to reset values.
  - A sync input that is high at reset release produces a spurious rise. This yields at most one bad frame in CHECK and never a false lock.
- hs_rise and vs_rise in the same cycle is the normal frame boundary, not an error.

## Configuration
- VGA_RX_MEAS_EN defined:
  - h_total_meas is loaded with the line period at every hs_rise.
  - v_total_meas is loaded with line index + 1 at every vs_rise.
  - Both are updated in any FSM state and reset to 0.
- VGA_RX_MEAS_EN undefined: both ports are tied to 0, and no measurement registers exist.

## Test plan
- Generator in loopback from reset -> locked rises 1 cycle after the 3rd detected vsync rise (2 good frames, 840000 cycles after the 1st). err_pulse stays 0.
- Locked, generator drawing x-y gradient -> exactly 640x480 pix_valid per frame. (pix_x, pix_y, pix_data) match the driven values with 2-cycle latency. frame_start fires once per frame at (0,0).
- Locked, one line stretched to 801 clocks -> err_pulse fires once at h position 800, locked falls. Relock occurs after 2 subsequent good frames.
- Locked, vsync suppressed for one frame -> line index exceeds 524 and the next vs_rise is bad, so the block unlocks. pix_valid stays 0 until relock.
- Source is 800x524 -> locked never rises. With VGA_RX_MEAS_EN: v_total_meas = 524 and h_total_meas = 800.
- rst_n asserted mid-frame while locked -> all outputs take reset values immediately. The block relocks within 3 frames of release.
